// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns a pipeline memory access into a single
// registered bus transaction, stalls the pipeline while it waits, and aborts on timeout.
module mem_access_unit #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic        MEM_mem_re,
  input  logic        MEM_mem_we,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_alu_c,
  input  logic [31:0] MEM_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] MEM_rd,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        access, is_store, legal;
  logic        accept, ack_ok, timed_out;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  assign access   = MEM_valid & (MEM_mem_re | MEM_mem_we);
  // A store wins when both request lines are high.
  assign is_store = MEM_mem_we;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    legal = 1'b0;
    case (MEM_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~MEM_alu_c[0];
      3'b010:  legal = (MEM_alu_c[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~MEM_alu_c[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = '0;
    if (is_store) begin
      case (MEM_funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << MEM_alu_c[1:0];
          wdata_nxt = {4{MEM_wdata[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << {MEM_alu_c[1], 1'b0};
          wdata_nxt = {2{MEM_wdata[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = MEM_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_stall    = 1'b0;
    misalign_exc = 1'b0;
    accept       = 1'b0;
    ack_ok       = 1'b0;
    timed_out    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (access) begin
            if (legal) begin
              mem_stall = 1'b1;
              accept    = 1'b1;
              state_nxt = REQ;
            end else begin
              misalign_exc = 1'b1;
            end
          end
        end
        REQ: begin
          mem_stall = 1'b1;
          // An ack on the final counted cycle still completes normally.
          if (bus_ack) begin
            ack_ok    = 1'b1;
            state_nxt = DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            timed_out = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      MEM_rd    <= '0;
      bus_err   <= 1'b0;
      tmo_cnt   <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {MEM_alu_c[31:2], 2'b00};
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
            f3_q      <= MEM_funct3;
            lane_q    <= MEM_alu_c[1:0];
            tmo_cnt   <= '0;
          end else if (misalign_exc) begin
            MEM_rd <= '0;
          end
        end
        REQ: begin
          if (ack_ok) begin
            bus_req <= 1'b0;
            if (!bus_we) MEM_rd <= extend(f3_q, lane_q, bus_rdata);
          end else if (timed_out) begin
            bus_req <= 1'b0;
            MEM_rd  <= '0;
            bus_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE:    bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus
// hand-written timeout, late-ack and reset-during-request sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid, MEM_mem_re, MEM_mem_we;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_alu_c, MEM_wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic [31:0] MEM_rd;
  logic        misalign_exc, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MEM_valid(MEM_valid), .MEM_mem_re(MEM_mem_re), .MEM_mem_we(MEM_mem_we),
    .MEM_funct3(MEM_funct3), .MEM_alu_c(MEM_alu_c), .MEM_wdata(MEM_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .MEM_rd(MEM_rd), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        mis;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic run_vec(input int idx, input vec_t v);
    MEM_valid  = 1'b1;
    MEM_mem_re = v.re;
    MEM_mem_we = v.we;
    MEM_funct3 = v.f3;
    MEM_alu_c  = v.addr;
    MEM_wdata  = v.wdata;
    bus_ack    = 1'b0;
    #1;
    check($sformatf("v%0d_idle_stall", idx), mem_stall, !v.mis);
    check($sformatf("v%0d_misalign", idx), misalign_exc, v.mis);
    @(negedge clk);
    if (v.mis) begin
      MEM_valid = 1'b0;
      #1;
      check($sformatf("v%0d_mis_noreq", idx), bus_req, 0);
      check($sformatf("v%0d_mis_stall", idx), mem_stall, 0);
      check($sformatf("v%0d_mis_rd", idx), MEM_rd, v.rd);
    end else begin
      check($sformatf("v%0d_req", idx), bus_req, 1);
      check($sformatf("v%0d_req_stall", idx), mem_stall, 1);
      check($sformatf("v%0d_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_be", idx), bus_be, v.be);
      check($sformatf("v%0d_wdata", idx), bus_wdata, v.bwd);
      check($sformatf("v%0d_we", idx), bus_we, v.we);
      bus_ack   = 1'b1;
      bus_rdata = v.rdata;
      @(negedge clk);
      bus_ack   = 1'b0;
      #1;
      check($sformatf("v%0d_done_stall", idx), mem_stall, 0);
      check($sformatf("v%0d_done_req", idx), bus_req, 0);
      check($sformatf("v%0d_rd", idx), MEM_rd, v.rd);
      check($sformatf("v%0d_done_err", idx), bus_err, 0);
      MEM_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_done_noaccept", idx), bus_req, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   req_cycles;

    //          re we  f3      addr          wdata         rdata         be       bwd           mis  rd
    vecs[0]  = '{1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        0, 32'hDEAD_BEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1111, 32'h0,        0, 32'hFFFF_FF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1111, 32'h0,        0, 32'h0000_0080};
    vecs[3]  = '{1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_0000, 4'b1111, 32'h0,        0, 32'h0000_80FF};
    vecs[4]  = '{1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 4'b1111, 32'h0,        0, 32'hFFFF_80FF};
    vecs[5]  = '{0, 1, 3'b000, 32'h0000_0202, 32'h1234_5678, 32'h0,       4'b0100, 32'h7878_7878, 0, 32'hFFFF_80FF};
    vecs[6]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0,       4'b1100, 32'h5678_5678, 0, 32'hFFFF_80FF};
    vecs[7]  = '{0, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,       4'b1111, 32'hCAFE_F00D, 0, 32'hFFFF_80FF};
    vecs[8]  = '{1, 1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,       4'b0010, 32'hABAB_ABAB, 0, 32'hFFFF_80FF};
    vecs[9]  = '{1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        4'b1111, 32'h0,        1, 32'h0};
    vecs[10] = '{1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 4'b1111, 32'h0,        0, 32'h0000_007F};
    vecs[11] = '{0, 1, 3'b001, 32'h0000_0203, 32'h1111_2222, 32'h0,       4'b0000, 32'h0,        1, 32'h0};
    vecs[12] = '{1, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_ABCD, 4'b1111, 32'h0,        0, 32'h0000_ABCD};
    vecs[13] = '{0, 1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'h0};
    vecs[14] = '{1, 0, 3'b011, 32'h0000_0200, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'h0};
    vecs[15] = '{1, 0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_8001, 4'b1111, 32'h0,        0, 32'hFFFF_8001};
    vecs[16] = '{1, 0, 3'b000, 32'h0000_0102, 32'h0,        32'h0080_0000, 4'b1111, 32'h0,        0, 32'hFFFF_FF80};

    rst = 1'b1; MEM_valid = 1'b0; MEM_mem_re = 1'b0; MEM_mem_we = 1'b0;
    MEM_funct3 = '0; MEM_alu_c = '0; MEM_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req", bus_req, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_rd", MEM_rd, 0);
    check("rst_err", bus_err, 0);
    check("rst_stall", mem_stall, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Ack withheld: bus_req for exactly 4 cycles, then DONE with bus_err.
    MEM_valid = 1'b1; MEM_mem_re = 1'b1; MEM_mem_we = 1'b0;
    MEM_funct3 = 3'b010; MEM_alu_c = 32'h0000_0300;
    @(negedge clk);
    req_cycles = 0;
    for (int i = 0; i < 10 && mem_stall; i++) begin
      if (bus_req) req_cycles++;
      @(negedge clk);
    end
    check("tmo_stall_end", mem_stall, 0);
    check("tmo_req_cycles", req_cycles, 4);
    check("tmo_err", bus_err, 1);
    check("tmo_rd", MEM_rd, 0);
    check("tmo_req_low", bus_req, 0);
    MEM_valid = 1'b0;
    @(negedge clk);
    check("tmo_err_clear", bus_err, 0);
    @(negedge clk);

    // Ack on the final counted cycle completes normally.
    MEM_valid = 1'b1; MEM_alu_c = 32'h0000_0304;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("late_ack_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'h55AA_1234;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("late_ack_err", bus_err, 0);
    check("late_ack_rd", MEM_rd, 32'h55AA_1234);
    check("late_ack_stall", mem_stall, 0);
    MEM_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset on the second REQ cycle, then a stray ack.
    MEM_valid = 1'b1; MEM_alu_c = 32'h0000_0400;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    MEM_alu_c = 32'h0000_0401;
    #1;
    check("rstreq_stall", mem_stall, 0);
    check("rstreq_mis", misalign_exc, 0);
    @(negedge clk);
    check("rstreq_req", bus_req, 0);
    check("rstreq_addr", bus_addr, 0);
    check("rstreq_be", bus_be, 0);
    check("rstreq_wdata", bus_wdata, 0);
    check("rstreq_rd", MEM_rd, 0);
    check("rstreq_err", bus_err, 0);
    rst = 1'b0; MEM_valid = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stray_ack_req", bus_req, 0);
    check("stray_ack_rd", MEM_rd, 0);
    check("stray_ack_err", bus_err, 0);
    check("stray_ack_stall", mem_stall, 0);
    bus_ack = 1'b0;
    @(negedge clk);
    v = vecs[0];
    run_vec(100, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter BUS_TIMEOUT, default 16: max cycles in REQ without bus_ack before abort; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 MEM_valid  in  1  MEM-stage instruction valid.
REQ-005 MEM_mem_re / MEM_mem_we  in  1 each  load / store request; if both high, store wins.
REQ-006 MEM_funct3  in  3  RV32I width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 MEM_alu_c  in  32  effective byte address.
REQ-008 MEM_wdata  in  32  store data (rs2).
REQ-009 bus_req / bus_we  out  1 each  bus request / write strobe; registered.
REQ-010 bus_addr  out  32  word address {MEM_alu_c[31:2],2'b00}; registered.
REQ-011 bus_be / bus_wdata  out  4 / 32  byte enables / lane-aligned write data; registered.
REQ-012 bus_ack / bus_rdata  in  1 / 32  completion strobe / read word, valid with bus_ack.
REQ-013 mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
REQ-014 MEM_rd  out  32  extended load result, feeds MEM/WB; registered.
REQ-015 misalign_exc / bus_err  out  1 each  misaligned/unsupported-access flag / bus-timeout flag.

Function
REQ-016 States: IDLE, REQ, DONE.
REQ-017 Access = MEM_valid & (MEM_mem_re | MEM_mem_we); non-access in IDLE: no state change, mem_stall=0.
REQ-018 Legal: funct3 000/100 any address; 001/101 addr[0]=0; 010 addr[1:0]=0; stores only 000/001/010.
REQ-019 IDLE + legal access: mem_stall=1 combinationally; capture bus_addr/bus_be/bus_wdata/bus_we, funct3, addr[1:0]; bus_req<=1; next REQ.
REQ-020 IDLE + illegal access: misalign_exc=1 combinationally that cycle, mem_stall=0, no bus_req, MEM_rd<=0, stay IDLE.
REQ-021 Store lanes: sb be=4'b0001<<addr[1:0], byte replicated x4; sh be=4'b0011<<{addr[1],1'b0}, half replicated x2; sw be=4'b1111.
REQ-022 Loads: bus_we=0, bus_be=4'b1111, bus_wdata=0.
REQ-023 REQ: mem_stall=1; bus_req held with stable addr/be/wdata until ack or timeout.
REQ-024 REQ + bus_ack: bus_req<=0; loads set MEM_rd<=extended lane of bus_rdata; stores leave MEM_rd unchanged; next DONE.
REQ-025 Extension: lb/lh sign-extend, lbu/lhu zero-extend; byte lane addr[1:0], half lane addr[1]; lw whole word.
REQ-026 Timeout counter clears on REQ entry, increments each REQ cycle without ack; at BUS_TIMEOUT: bus_req<=0, MEM_rd<=0, bus_err<=1, next DONE.
REQ-027 Ack on the same cycle the counter reaches BUS_TIMEOUT counts as success; no bus_err.
REQ-028 DONE: exactly one cycle; mem_stall=0 so pipeline advances; no new access accepted; next IDLE; bus_err cleared on exit.
REQ-029 Latency: ack in first REQ cycle -> 2 stall cycles, result in MEM_rd in 3rd (DONE) cycle; each wait cycle adds one.
REQ-030 bus_ack outside REQ is ignored.
REQ-031 MEM_rd holds its value between completions.

Reset
REQ-032 On rst sampled high: state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, MEM_rd, bus_err, counter all 0.
REQ-033 rst in REQ: bus_req drops at that edge; late ack ignored per REQ-030; no bus_err.
REQ-034 While rst high: mem_stall=0, misalign_exc=0.

Verification
REQ-035 lw addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, stall 2 cycles, MEM_rd=0xDEADBEEF in DONE.
REQ-036 lb addr 0x103, rdata 0x80FF_0000 -> MEM_rd=0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x102 -> 0x000080FF.
REQ-037 sb addr 0x0202, wdata 0x12345678 -> bus_be 0100, bus_wdata 0x78787878, bus_we 1; sh addr 0x0202 -> be 1100, wdata 0x56785678.
REQ-038 lw addr 0x101 -> misalign_exc=1 one cycle, no bus_req, mem_stall 0, MEM_rd 0.
REQ-039 lw, ack withheld, BUS_TIMEOUT=4 -> bus_req high 4 cycles, then DONE with bus_err=1, MEM_rd=0; ack on 4th cycle instead -> normal completion.
REQ-040 rst asserted on 2nd REQ cycle, ack following cycle -> all outputs 0, state IDLE, ack ignored, next legal access proceeds normally.
